// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response bundle between fetch and imem.
// master = fetch stage, slave = instruction memory.
interface fetch_unit_if;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_rdy;
    logic [15:0] imem_data;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_rdy,
        input  imem_data
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_rdy,
        output imem_data
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch stage of the 16-bit WISC core: PC, imem requests,
// output register plus one-entry skid buffer, redirect and HLT handling.
module fetch_unit #(
    parameter logic [15:0] RESET_PC    = 16'h0000,
    parameter logic [3:0]  HALT_OPCODE = 4'hF,
    parameter logic [15:0] PC_STEP     = 16'd2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                stall_i,
    input  logic                redirect_i,
    input  logic [15:0]         redirect_pc_i,
    fetch_unit_if.master        imem,
    output logic                inst_valid_o,
    output logic [15:0]         inst_o,
    output logic [15:0]         inst_pc_o,
    output logic [15:0]         inst_pc_next_o,
    output logic                hlt_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_SQUASH,
        S_HALTED
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] sq_addr_q, sq_addr_d;
    logic        out_v_q, out_v_d;
    logic [15:0] out_inst_q, out_inst_d;
    logic [15:0] out_pc_q, out_pc_d;
    logic [15:0] out_pcn_q, out_pcn_d;
    logic        skid_v_q, skid_v_d;
    logic [15:0] skid_inst_q, skid_inst_d;
    logic [15:0] skid_pc_q, skid_pc_d;
    logic        hlt_q, hlt_d;

    logic        accept;
    logic        slot_free;
    logic        fetching;
    logic        req;
    logic        is_hlt;

    // Handshake terms; a request is live in IDLE (skid empty), BUSY and SQUASH.
    always_comb begin
        accept    = out_v_q & ~stall_i;
        slot_free = ~out_v_q | accept;
        fetching  = (state_q == S_BUSY) |
                    ((state_q == S_IDLE) & ~skid_v_q);
        req       = ~rst & (fetching | (state_q == S_SQUASH));
        is_hlt    = (imem.imem_data[15:12] == HALT_OPCODE);
    end

    assign imem.imem_req  = req;
    assign imem.imem_addr = (state_q == S_SQUASH) ? sq_addr_q : pc_q;

    assign inst_valid_o   = out_v_q;
    assign inst_o         = out_inst_q;
    assign inst_pc_o      = out_pc_q;
    assign inst_pc_next_o = out_pcn_q;
    assign hlt_o          = hlt_q;

    // Next-state: drain to decode, then redirect, squash or capture a response.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        sq_addr_d   = sq_addr_q;
        out_v_d     = out_v_q;
        out_inst_d  = out_inst_q;
        out_pc_d    = out_pc_q;
        out_pcn_d   = out_pcn_q;
        skid_v_d    = skid_v_q;
        skid_inst_d = skid_inst_q;
        skid_pc_d   = skid_pc_q;
        hlt_d       = hlt_q;

        if (accept) begin
            if (skid_v_q) begin
                out_inst_d = skid_inst_q;
                out_pc_d   = skid_pc_q;
                out_pcn_d  = skid_pc_q + PC_STEP;
                skid_v_d   = 1'b0;
            end else begin
                out_v_d = 1'b0;
            end
        end

        if (redirect_i) begin
            out_v_d  = 1'b0;
            skid_v_d = 1'b0;
            hlt_d    = 1'b0;
            pc_d     = redirect_pc_i;
            if (req & ~imem.imem_rdy) begin
                state_d = S_SQUASH;
                if (state_q != S_SQUASH) begin
                    sq_addr_d = pc_q;
                end
            end else begin
                state_d = S_IDLE;
            end
        end else if (state_q == S_SQUASH) begin
            if (imem.imem_rdy) begin
                state_d = S_IDLE;
            end
        end else if (fetching & imem.imem_rdy) begin
            pc_d = pc_q + PC_STEP;
            if (slot_free) begin
                out_v_d    = 1'b1;
                out_inst_d = imem.imem_data;
                out_pc_d   = pc_q;
                out_pcn_d  = pc_q + PC_STEP;
            end else begin
                skid_v_d    = 1'b1;
                skid_inst_d = imem.imem_data;
                skid_pc_d   = pc_q;
            end
            if (is_hlt) begin
                state_d = S_HALTED;
                hlt_d   = 1'b1;
            end else if (~slot_free) begin
                state_d = S_IDLE;
            end else begin
                state_d = S_BUSY;
            end
        end else if (fetching) begin
            state_d = S_BUSY;
        end
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            pc_q        <= RESET_PC;
            sq_addr_q   <= 16'h0000;
            out_v_q     <= 1'b0;
            out_inst_q  <= 16'h0000;
            out_pc_q    <= 16'h0000;
            out_pcn_q   <= 16'h0000;
            skid_v_q    <= 1'b0;
            skid_inst_q <= 16'h0000;
            skid_pc_q   <= 16'h0000;
            hlt_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            sq_addr_q   <= sq_addr_d;
            out_v_q     <= out_v_d;
            out_inst_q  <= out_inst_d;
            out_pc_q    <= out_pc_d;
            out_pcn_q   <= out_pcn_d;
            skid_v_q    <= skid_v_d;
            skid_inst_q <= skid_inst_d;
            skid_pc_q   <= skid_pc_d;
            hlt_q       <= hlt_d;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit: transaction-level model of program
// order, squashed responses and HLT, plus directed reset/wrap checks.
module tb_fetch_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        stall;
    logic        redir;
    logic [15:0] redir_pc;
    logic        iv, hlt;
    logic [15:0] inst, ipc, ipcn;

    logic        stall2 = 1'b0;
    logic        redir2 = 1'b0;
    logic [15:0] redir_pc2 = 16'h0000;
    logic        iv2, hlt2;
    logic [15:0] inst2, ipc2, ipcn2;

    fetch_unit_if mif ();
    fetch_unit_if mif2 ();

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        if (a[6:0] == 7'h2A) return {4'hF, a[11:0]};
        return {4'h1, a[11:0]};
    endfunction

    assign mif2.imem_rdy  = mif2.imem_req;
    assign mif2.imem_data = mem_word(mif2.imem_addr);

    fetch_unit dut (
        .clk           (clk),
        .rst           (rst),
        .stall_i       (stall),
        .redirect_i    (redir),
        .redirect_pc_i (redir_pc),
        .imem          (mif),
        .inst_valid_o  (iv),
        .inst_o        (inst),
        .inst_pc_o     (ipc),
        .inst_pc_next_o(ipcn),
        .hlt_o         (hlt)
    );

    fetch_unit #(.RESET_PC(16'hFFFE)) dut2 (
        .clk           (clk),
        .rst           (rst),
        .stall_i       (stall2),
        .redirect_i    (redir2),
        .redirect_pc_i (redir_pc2),
        .imem          (mif2),
        .inst_valid_o  (iv2),
        .inst_o        (inst2),
        .inst_pc_o     (ipc2),
        .inst_pc_next_o(ipcn2),
        .hlt_o         (hlt2)
    );

    typedef struct {
        logic [15:0] pc;
        logic [15:0] w;
    } ent_t;

    ent_t        q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [15:0] fetch_pc;
    logic        squash, mhalt, live;
    logic        prev_rst, prev_wait;
    logic [15:0] prev_addr;
    logic        pend;
    int          cnt;
    int          stuck;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cycle(input logic r, input logic s, input logic rd,
                         input logic [15:0] rpc, input int maxlat);
        logic req, rdy, acc;
        logic [15:0] addr;
        ent_t e;
        @(posedge clk);
        #1;
        rst = r; stall = s; redir = rd; redir_pc = rpc;
        #1;
        if (r || !mif.imem_req) begin
            pend = 1'b0;
            mif.imem_rdy  = 1'b0;
            mif.imem_data = 16'($urandom);
        end else begin
            if (!pend) begin
                pend = 1'b1;
                cnt  = $urandom_range(maxlat, 0);
            end
            if (cnt == 0) begin
                mif.imem_rdy  = 1'b1;
                mif.imem_data = mem_word(mif.imem_addr);
                pend = 1'b0;
            end else begin
                mif.imem_rdy  = 1'b0;
                mif.imem_data = 16'($urandom);
                cnt--;
            end
        end
        @(negedge clk);
        req  = mif.imem_req;
        rdy  = mif.imem_rdy;
        addr = mif.imem_addr;
        acc  = iv & ~s;

        if (prev_rst) begin
            check("rst_valid", 32'(iv), 32'd0);
            check("rst_inst", 32'(inst), 32'd0);
            check("rst_pc", 32'(ipc), 32'd0);
            check("rst_pcn", 32'(ipcn), 32'd0);
            check("rst_hlt", 32'(hlt), 32'd0);
            if (r) check("rst_req", 32'(req), 32'd0);
        end
        if (live && prev_wait && !r) begin
            check("hold_req", 32'(req), 32'd1);
            check("hold_addr", 32'(addr), 32'(prev_addr));
        end
        if (live) begin
            check("valid", 32'(iv), 32'(q.size() != 0));
            if (q.size() != 0) begin
                check("inst", 32'(inst), 32'(q[0].w));
                check("inst_pc", 32'(ipc), 32'(q[0].pc));
                check("inst_pcn", 32'(ipcn), 32'(16'(q[0].pc + 16'd2)));
            end
            check("hlt", 32'(hlt), 32'(mhalt));
            if (mhalt && !r) check("halt_req", 32'(req), 32'd0);
        end

        if (r) begin
            q.delete();
            fetch_pc = 16'h0000;
            squash = 1'b0;
            mhalt  = 1'b0;
            live   = 1'b1;
            stuck  = 0;
        end else begin
            if (acc && q.size() != 0) void'(q.pop_front());
            if (acc || rd || mhalt) stuck = 0;
            else if (live) stuck++;
            if (stuck == 80) check("progress", 32'(stuck), 32'd0);
            if (rd) begin
                squash = req & ~rdy;
                q.delete();
                mhalt = 1'b0;
                fetch_pc = rpc;
            end else if (req && rdy) begin
                if (squash) begin
                    squash = 1'b0;
                end else begin
                    check("fetch_addr", 32'(addr), 32'(fetch_pc));
                    e.pc = fetch_pc;
                    e.w  = mem_word(fetch_pc);
                    q.push_back(e);
                    if (e.w[15:12] == 4'hF) mhalt = 1'b1;
                    fetch_pc = fetch_pc + 16'd2;
                end
            end
        end
        prev_rst  = r;
        prev_wait = req & ~rdy & ~r;
        prev_addr = addr;
    endtask

    initial begin
        int stall_pct;
        logic [15:0] rpc;
        rst = 1'b1; stall = 1'b0; redir = 1'b0; redir_pc = 16'h0000;
        mif.imem_rdy = 1'b0; mif.imem_data = 16'h0000;
        fetch_pc = 16'h0000; squash = 1'b0; mhalt = 1'b0; live = 1'b0;
        prev_rst = 1'b0; prev_wait = 1'b0; prev_addr = 16'h0000;
        pend = 1'b0; cnt = 0; stuck = 0;

        repeat (3) cycle(1'b1, 1'b0, 1'b0, 16'h0000, 0);

        for (int i = 0; i < 6; i++) begin
            cycle(1'b0, 1'b0, 1'b0, 16'h0000, 0);
            if (i < 4) begin
                check("zw_req", 32'(mif.imem_req), 32'd1);
                check("zw_addr", 32'(mif.imem_addr), 32'(2 * i));
            end
            if (i == 0) check("wrap_a0", 32'(mif2.imem_addr), 32'h0000FFFE);
            if (i == 1) begin
                check("wrap_a1", 32'(mif2.imem_addr), 32'd0);
                check("wrap_pc", 32'(ipc2), 32'h0000FFFE);
                check("wrap_pcn", 32'(ipcn2), 32'd0);
            end
        end

        for (int i = 0; i < 3000; i++) begin
            case ((i / 500) % 3)
                0: stall_pct = 0;
                1: stall_pct = 30;
                default: stall_pct = 70;
            endcase
            rpc = 16'($urandom_range(0, 127)) << 1;
            if ($urandom_range(0, 7) == 0) rpc = 16'hFFF8;
            cycle(1'b0,
                  $urandom_range(0, 99) < stall_pct,
                  $urandom_range(0, 99) < 3,
                  rpc, (i % 1000 < 500) ? 0 : 3);
        end

        for (int i = 0; i < 20; i++) begin
            cycle(1'b0, 1'b0, 1'b0, 16'h0000, 8);
            if (pend) break;
        end
        cycle(1'b1, 1'b0, 1'b0, 16'h0000, 0);
        cycle(1'b1, 1'b0, 1'b0, 16'h0000, 0);
        repeat (20) cycle(1'b0, 1'b0, 1'b0, 16'h0000, 2);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
